// File: rtl/cprv_mem_pkg.sv
// Shared types and helpers for the cprv single-port memory blocks.
package cprv_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 7;
    localparam int unsigned MEM_DATA_W = 64;

    // Number of byte lanes in a word of the given width.
    function automatic int unsigned strb_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

    typedef struct packed {
        logic                      w_en;
        logic [MEM_ADDR_W-1:0]     addr;
        logic [MEM_DATA_W/8-1:0]   wstrb;
        logic [MEM_DATA_W-1:0]     wdata;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0]     rdata;
        logic                      err;
    } mem_rsp_t;

endpackage

// File: rtl/cprv_ram_1p_be.sv
// Byte-enabled single-port array with READ_LAT registered read stages.
// Data storage and read stages carry no reset.
module cprv_ram_1p_be
    import cprv_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_W,
    parameter int unsigned DATA_WIDTH = MEM_DATA_W,
    parameter int unsigned DEPTH      = 2**ADDR_WIDTH,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic                                re,
    input  logic [ADDR_WIDTH-1:0]               addr,
    input  logic [strb_width(DATA_WIDTH)-1:0]   wstrb,
    input  logic [DATA_WIDTH-1:0]               wdata,
    output logic [DATA_WIDTH-1:0]               rdata
);

    localparam int unsigned STRB_W = strb_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem   [DEPTH];
    logic [DATA_WIDTH-1:0] stage [READ_LAT];

    // Byte-lane writes; lanes with a clear strobe keep their contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned k = 0; k < STRB_W; k++) begin
                if (wstrb[k]) begin
                    mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
                end
            end
        end
    end

    // Read stage 0 captures the array; later stages just delay it.
    always_ff @(posedge clk) begin
        if (re) begin
            stage[0] <= mem[addr];
        end
        for (int unsigned i = 1; i < READ_LAT; i++) begin
            stage[i] <= stage[i-1];
        end
    end

    assign rdata = stage[READ_LAT-1];

endmodule

// File: rtl/cprv_ram_1p_pipe.sv
// Single-port RAM with valid/ready request and response channels,
// credit-based flow control and a fall-through response buffer.
module cprv_ram_1p_pipe
    import cprv_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_W,
    parameter int unsigned DATA_WIDTH = MEM_DATA_W,
    parameter int unsigned DEPTH      = 2**ADDR_WIDTH,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned RBUF_DEPTH = READ_LAT + 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic                                w_en,
    input  logic [ADDR_WIDTH-1:0]               addr,
    input  logic [strb_width(DATA_WIDTH)-1:0]   wstrb,
    input  logic [DATA_WIDTH-1:0]               wdata,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [DATA_WIDTH-1:0]               rdata,
    output logic                                err_o
);

    localparam int unsigned CW = $clog2(RBUF_DEPTH + 1);
    localparam int unsigned PW = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_t;

    logic                  accept, rd_accept, wr_accept, in_range;
    logic [READ_LAT-1:0]   pipe_vld, pipe_err;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic                  arr_vld;
    rsp_t                  arr_rsp, head_rsp;
    rsp_t                  rbuf_mem [RBUF_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         rbuf_cnt, credit_cnt;
    logic                  rdy_en, rbuf_empty, rsp_hs, push, pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(RBUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_range  = (32'(addr) < DEPTH);
    assign accept    = valid_i & ready_o;
    assign rd_accept = accept & ~w_en;
    assign wr_accept = accept & w_en;

    // ready_o depends only on registered state: credits held by reads in
    // flight or buffered, gated off until the first edge after reset.
    assign ready_o = rdy_en & (credit_cnt < CW'(RBUF_DEPTH));

    cprv_ram_1p_be #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .READ_LAT   (READ_LAT)
    ) u_array (
        .clk   (clk),
        .we    (wr_accept & in_range),
        .re    (rd_accept & in_range),
        .addr  (addr),
        .wstrb (wstrb),
        .wdata (wdata),
        .rdata (arr_rdata)
    );

    // Valid/error tags travel alongside the array read stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_err <= '0;
        end else begin
            pipe_vld[0] <= rd_accept;
            pipe_err[0] <= rd_accept & ~in_range;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_err[i] <= pipe_err[i-1];
            end
        end
    end

    // Head selection: buffered entries take priority, otherwise the array
    // output falls straight through to the response port.
    always_comb begin
        arr_vld       = pipe_vld[READ_LAT-1];
        arr_rsp.err   = pipe_err[READ_LAT-1];
        arr_rsp.rdata = pipe_err[READ_LAT-1] ? '0 : arr_rdata;
        rbuf_empty    = (rbuf_cnt == '0);
        head_rsp      = rbuf_empty ? arr_rsp : rbuf_mem[rd_ptr];
        valid_o       = ~rbuf_empty | arr_vld;
        rsp_hs        = valid_o & ready_i;
        pop           = rsp_hs & ~rbuf_empty;
        push          = arr_vld & ~(rbuf_empty & ready_i);
        rdata         = valid_o ? head_rsp.rdata : '0;
        err_o         = valid_o & head_rsp.err;
    end

    // Response buffer storage (no reset on data).
    always_ff @(posedge clk) begin
        if (push) begin
            rbuf_mem[wr_ptr] <= arr_rsp;
        end
    end

    // Response buffer pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rbuf_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            rbuf_cnt <= rbuf_cnt + CW'(push) - CW'(pop);
        end
    end

    // Credit counter: taken on read accept, returned on response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= '0;
            rdy_en     <= 1'b0;
        end else begin
            credit_cnt <= credit_cnt + CW'(rd_accept) - CW'(rsp_hs);
            rdy_en     <= 1'b1;
        end
    end

    // The credit scheme guarantees the buffer can never overflow.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(push && (rbuf_cnt == CW'(RBUF_DEPTH))))
        else $error("cprv_ram_1p_pipe: response buffer push while full");

endmodule

// File: tb/tb_cprv_ram_1p_pipe.sv
// Directed, table-driven bench for cprv_ram_1p_pipe (DEPTH=100, READ_LAT=2).
module tb_cprv_ram_1p_pipe;

    localparam int unsigned AW  = 7;
    localparam int unsigned DW  = 64;
    localparam int unsigned SW  = 8;
    localparam int unsigned DEP = 100;
    localparam int unsigned RL  = 2;
    localparam int unsigned RB  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic          w_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [SW-1:0] wstrb = '0;
    logic [DW-1:0] wdata = '0;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [DW-1:0] rdata;
    logic          err_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cprv_ram_1p_pipe #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .READ_LAT   (RL),
        .RBUF_DEPTH (RB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .w_en    (w_en),
        .addr    (addr),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .rdata   (rdata),
        .err_o   (err_o)
    );

    typedef struct {
        logic          w_en;
        logic [AW-1:0] addr;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] sw(input int i);
        return {16'hC0DE, 16'(i), 16'hF00D, 16'(i * 3)};
    endfunction

    // One request with ready_i=1; reads check latency, data and error flag.
    task automatic do_txn(input int idx, input vec_t v);
        int n;
        @(negedge clk);
        valid_i = 1'b1;
        w_en    = v.w_en;
        addr    = v.addr;
        wstrb   = v.wstrb;
        wdata   = v.wdata;
        n = 0;
        while (!ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check($sformatf("vec%0d accept timeout", idx), 0, 1);
        @(negedge clk);
        valid_i = 1'b0;
        if (!v.w_en) begin
            n = 1;
            while (!valid_o && n < 10) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("vec%0d latency", idx), 64'(n), 64'(RL));
            check($sformatf("vec%0d rdata", idx), rdata, v.exp_rdata);
            check($sformatf("vec%0d err_o", idx), 64'(err_o), 64'(v.exp_err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, got, acc;
        logic seen, hold_ok, fourth, vld_seen;
        logic [DW-1:0] held;

        vecs[0]  = '{1'b1, 7'd5,   8'hFF, 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0};
        vecs[1]  = '{1'b1, 7'd5,   8'h01, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 1'b0};
        vecs[2]  = '{1'b0, 7'd5,   8'h00, 64'h0, 64'hDEAD_BEEF_0123_45AA, 1'b0};
        vecs[3]  = '{1'b1, 7'd6,   8'hFF, 64'h1111_2222_3333_4444, 64'h0, 1'b0};
        vecs[4]  = '{1'b1, 7'd6,   8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0};
        vecs[5]  = '{1'b0, 7'd6,   8'h00, 64'h0, 64'h1111_2222_3333_4444, 1'b0};
        vecs[6]  = '{1'b1, 7'd6,   8'hF0, 64'h5555_6666_7777_8888, 64'h0, 1'b0};
        vecs[7]  = '{1'b0, 7'd6,   8'h00, 64'h0, 64'h5555_6666_3333_4444, 1'b0};
        vecs[8]  = '{1'b0, 7'd120, 8'h00, 64'h0, 64'h0, 1'b1};
        vecs[9]  = '{1'b1, 7'd20,  8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
        vecs[10] = '{1'b1, 7'd120, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0};
        vecs[11] = '{1'b0, 7'd20,  8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[12] = '{1'b1, 7'd99,  8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 1'b0};
        vecs[13] = '{1'b0, 7'd99,  8'h00, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0};
        vecs[14] = '{1'b0, 7'd100, 8'h00, 64'h0, 64'h0, 1'b1};
        vecs[15] = '{1'b0, 7'd127, 8'h00, 64'h0, 64'h0, 1'b1};

        // Reset state
        #1;
        check("reset ready_o", 64'(ready_o), 0);
        check("reset valid_o", 64'(valid_o), 0);
        check("reset err_o",   64'(err_o),   0);
        check("reset rdata",   rdata,        0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release ready_o low", 64'(ready_o), 0);
        @(negedge clk);
        check("release ready_o high", 64'(ready_o), 1);

        // Table of single transactions
        for (int i = 0; i < 16; i++) do_txn(i, vecs[i]);

        // Read immediately after writes to the same word, partial strobe
        @(negedge clk);
        valid_i = 1'b1; w_en = 1'b1; addr = 7'd40; wstrb = 8'hFF; wdata = 64'h1234_5678_9ABC_DEF0;
        check("raw ready0", 64'(ready_o), 1);
        @(negedge clk);
        wstrb = 8'h0C; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        check("raw ready1", 64'(ready_o), 1);
        @(negedge clk);
        w_en = 1'b0;
        check("raw ready2", 64'(ready_o), 1);
        @(negedge clk);
        valid_i = 1'b0;
        n = 1;
        while (!valid_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("raw latency", 64'(n), 64'(RL));
        check("raw rdata", rdata, 64'h1234_5678_FFFF_DEF0);
        check("raw err_o", 64'(err_o), 0);
        @(negedge clk);

        // Streaming reads with ready_i=1
        for (int i = 0; i < 8; i++) do_txn(100 + i, '{1'b1, AW'(i), 8'hFF, sw(i), 64'h0, 1'b0});
        got = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (valid_o) begin
                check($sformatf("stream rsp%0d", got), rdata, sw(got));
                check($sformatf("stream slot%0d", got), 64'(c), 64'(got + 2));
                got++;
            end
            if (c < 8) begin
                check($sformatf("stream ready%0d", c), 64'(ready_o), 1);
                valid_i = 1'b1; w_en = 1'b0; addr = AW'(c);
            end else begin
                valid_i = 1'b0;
            end
        end
        check("stream count", 64'(got), 8);

        // Backpressure: four reads offered while ready_i=0
        ready_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b1; w_en = 1'b0; addr = '0;
        acc = 0; seen = 1'b0; hold_ok = 1'b1; held = '0;
        for (int c = 0; c < 8; c++) begin
            if (valid_o) begin
                if (!seen) begin
                    seen = 1'b1;
                    held = rdata;
                end else if (rdata !== held || err_o !== 1'b0) begin
                    hold_ok = 1'b0;
                end
            end else if (seen) begin
                hold_ok = 1'b0;
            end
            if (ready_o) acc++;
            @(negedge clk);
            addr = AW'(acc);
        end
        check("bp accepts", 64'(acc), 3);
        check("bp ready_o", 64'(ready_o), 0);
        check("bp valid_o", 64'(valid_o), 1);
        check("bp held data", held, sw(0));
        check("bp hold stable", 64'(hold_ok), 1);
        ready_i = 1'b1;
        got = 0; fourth = 1'b0;
        for (int c = 0; c < 12 && got < 4; c++) begin
            if (valid_o) begin
                check($sformatf("bp rsp%0d", got), rdata, sw(got));
                got++;
            end
            if (valid_i && ready_o) fourth = 1'b1;
            @(negedge clk);
            if (fourth) valid_i = 1'b0;
        end
        valid_i = 1'b0;
        check("bp drained", 64'(got), 4);
        check("bp fourth accepted", 64'(fourth), 1);

        // Reset with two reads in flight
        ready_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b1; w_en = 1'b0; addr = 7'd0;
        @(negedge clk);
        addr = 7'd1;
        @(negedge clk);
        valid_i = 1'b0;
        check("burst valid before reset", 64'(valid_o), 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst ready_o", 64'(ready_o), 0);
        check("midrst valid_o", 64'(valid_o), 0);
        check("midrst err_o",   64'(err_o),   0);
        check("midrst rdata",   rdata,        0);
        ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst release ready_o low", 64'(ready_o), 0);
        @(negedge clk);
        check("midrst release ready_o high", 64'(ready_o), 1);
        vld_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (valid_o) vld_seen = 1'b1;
            @(negedge clk);
        end
        check("midrst no stale response", 64'(vld_seen), 0);
        ready_i = 1'b0;
        valid_i = 1'b1; w_en = 1'b0; addr = 7'd2;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            if (ready_o) acc++;
            @(negedge clk);
        end
        valid_i = 1'b0;
        check("midrst credits restored", 64'(acc), 3);
        ready_i = 1'b1;
        repeat (6) @(negedge clk);
        check("final ready_o", 64'(ready_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
